branch_target_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Lets the fetch stage redirect the PC before the execute stage resolves the branch.
- Lookup is combinational on the fetch-stage PC.
- Training uses resolved branch/jump outcomes from the execute stage, registered on the clock edge.
- Sits beside the PC register and the PC+4 adder, and adds early redirection that the current execute-resolved PC select does not provide.

---
 rtl/branch_target_predictor_pkg.sv | 23 ++
 rtl/branch_target_predictor_if.sv | 30 +++
 rtl/branch_target_predictor_sat_counter2.sv | 36 +++
 rtl/branch_target_predictor.sv | 102 ++++++++++
 tb/tb_branch_target_predictor.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor: direction-counter encodings
// and the PC index/tag slicing helpers.
package branch_target_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup and execute-training bus of the branch target predictor.
interface branch_target_predictor_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
);
    logic              inval;
    logic [XLEN-1:0]   pc_f;
    logic              hit_f;
    logic              taken_f;
    logic [XLEN-1:0]   target_f;
    logic [XLEN-1:0]   next_pc_f;
    logic              upd_en;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_jump;
    logic              upd_mispredict;
    logic [PERF_W-1:0] upd_count;
    logic [PERF_W-1:0] mispredict_count;

    modport master (
        output inval, pc_f, upd_en, upd_pc, upd_taken, upd_target, upd_jump, upd_mispredict,
        input  hit_f, taken_f, target_f, next_pc_f, upd_count, mispredict_count
    );

    modport slave (
        input  inval, pc_f, upd_en, upd_pc, upd_taken, upd_target, upd_jump, upd_mispredict,
        output hit_f, taken_f, target_f, next_pc_f, upd_count, mispredict_count
    );
endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// 2-bit saturating up/down direction counter with synchronous clear and force.
module sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic force_en,
    input  ctr_e force_val,
    input  logic inc,
    input  logic dec,
    output ctr_e ctr
);
    ctr_e ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clear) begin
            ctr_d = CTR_RESET;
        end else if (force_en) begin
            ctr_d = force_val;
        end else if (inc) begin
            if (ctr_q != ST) ctr_d = ctr_e'(ctr_q + 2'd1);
        end else if (dec) begin
            if (ctr_q != SNT) ctr_d = ctr_e'(ctr_q - 2'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctr_q <= CTR_RESET;
        else     ctr_q <= ctr_d;
    end

    assign ctr = ctr_q;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
// Lookup is combinational on pc_f; training from execute is applied on the clock edge.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int PERF_W  = 32
) (
    input logic clk,
    input logic rst,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [IDX_W-1:0]  idx_f, upd_idx;
    logic [TAG_W-1:0]  tag_f, upd_tag;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [PERF_W-1:0]  upd_count_q, upd_count_d;
    logic [PERF_W-1:0]  mis_count_q, mis_count_d;
    ctr_e               ctr      [ENTRIES];

    logic upd_accept, upd_hit, upd_alloc, upd_write_tgt;

    assign idx_f   = IDX_W'(pc_index(64'(bus.pc_f), IDX_W));
    assign tag_f   = TAG_W'(pc_tag(64'(bus.pc_f), IDX_W));
    assign upd_idx = IDX_W'(pc_index(64'(bus.upd_pc), IDX_W));
    assign upd_tag = TAG_W'(pc_tag(64'(bus.upd_pc), IDX_W));

    // inval wins over a concurrent update; the update is then neither applied nor counted.
    assign upd_accept    = bus.upd_en & ~bus.inval;
    assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_alloc     = upd_accept & ~upd_hit & bus.upd_taken;
    assign upd_write_tgt = upd_accept & (upd_hit ? (bus.upd_jump | bus.upd_taken) : bus.upd_taken);

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        upd_count_d = upd_count_q;
        mis_count_d = mis_count_q;
        if (bus.inval) begin
            valid_d = '0;
        end else if (upd_alloc) begin
            valid_d[upd_idx] = 1'b1;
            tag_d[upd_idx]   = upd_tag;
        end
        if (upd_write_tgt) target_d[upd_idx] = bus.upd_target;
        if (upd_accept) begin
            upd_count_d = upd_count_q + PERF_W'(1);
            if (bus.upd_mispredict) mis_count_d = mis_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            upd_count_q <= '0;
            mis_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            upd_count_q <= upd_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic sel;
        assign sel = upd_accept && (upd_idx == IDX_W'(i));

        sat_counter2 u_ctr (
            .clk       (clk),
            .rst       (rst),
            .clear     (bus.inval),
            .force_en  (sel && (upd_hit ? bus.upd_jump : bus.upd_taken)),
            .force_val (bus.upd_jump ? ST : WT),
            .inc       (sel && upd_hit && bus.upd_taken),
            .dec       (sel && upd_hit && !bus.upd_taken),
            .ctr       (ctr[i])
        );
    end

    assign bus.hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign bus.taken_f          = bus.hit_f && ctr[idx_f][1];
    assign bus.target_f         = bus.hit_f ? target_q[idx_f] : '0;
    assign bus.next_pc_f        = bus.taken_f ? bus.target_f : bus.pc_f + XLEN'(4);
    assign bus.upd_count        = upd_count_q;
    assign bus.mispredict_count = mis_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: a behavioural BTB model compared
// every cycle, plus hand-computed literal expectations from directed vectors.
module tb_branch_target_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int PERF_W  = 3;

    logic clk = 1'b0;
    logic rst;
    logic check_en;
    int   nvec;
    int   nmis;

    always #5 clk = ~clk;

    branch_target_predictor_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

    branch_target_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural model: BTB described as plain arrays indexed by word address.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_upd;
    int unsigned m_mis;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic model_step();
        int unsigned ix;
        bit          hit;
        if (bus.inval) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else if (bus.upd_en) begin
            m_upd = (m_upd + 1) % (1 << PERF_W);
            if (bus.upd_mispredict) m_mis = (m_mis + 1) % (1 << PERF_W);
            ix  = idx_of(bus.upd_pc);
            hit = m_valid[ix] && (m_tag[ix] == tag_of(bus.upd_pc));
            if (hit) begin
                if (bus.upd_jump) begin
                    m_ctr[ix]    = 3;
                    m_target[ix] = bus.upd_target;
                end else if (bus.upd_taken) begin
                    m_ctr[ix]    = (m_ctr[ix] == 3) ? 3 : m_ctr[ix] + 1;
                    m_target[ix] = bus.upd_target;
                end else begin
                    m_ctr[ix]    = (m_ctr[ix] == 0) ? 0 : m_ctr[ix] - 1;
                end
            end else if (bus.upd_taken) begin
                m_valid[ix]  = 1'b1;
                m_tag[ix]    = tag_of(bus.upd_pc);
                m_target[ix] = bus.upd_target;
                m_ctr[ix]    = bus.upd_jump ? 3 : 2;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) model_step();
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int unsigned ix;
        bit          e_hit;
        bit          e_taken;
        logic [31:0] e_target;
        logic [31:0] e_next;
        ix       = idx_of(bus.pc_f);
        e_hit    = m_valid[ix] && (m_tag[ix] == tag_of(bus.pc_f));
        e_taken  = e_hit && (m_ctr[ix] >= 2);
        e_target = e_hit ? m_target[ix] : 32'h0;
        e_next   = e_taken ? e_target : bus.pc_f + 32'd4;
        compare("model hit_f",     32'(bus.hit_f),            32'(e_hit));
        compare("model taken_f",   32'(bus.taken_f),          32'(e_taken));
        compare("model target_f",  bus.target_f,              e_target);
        compare("model next_pc_f", bus.next_pc_f,             e_next);
        compare("model upd_count", 32'(bus.upd_count),        m_upd);
        compare("model mis_count", 32'(bus.mispredict_count), m_mis);
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) checkOutput();
    end

    task automatic idle();
        bus.upd_en         = 1'b0;
        bus.inval          = 1'b0;
        bus.upd_pc         = $urandom;
        bus.upd_target     = $urandom;
        bus.upd_taken      = 1'($urandom_range(0, 1));
        bus.upd_jump       = 1'($urandom_range(0, 1));
        bus.upd_mispredict = 1'($urandom_range(0, 1));
    endtask

    task automatic driveUpdate(input logic inv, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic jmp, input logic mis);
        bus.upd_en         = 1'b1;
        bus.inval          = inv;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_jump       = jmp;
        bus.upd_mispredict = mis;
    endtask

    task automatic applyStimulus(input logic inv, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic jmp, input logic mis);
        driveUpdate(inv, pc, tk, tgt, jmp, mis);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc, input logic e_hit, input logic e_taken,
                          input logic [31:0] e_next);
        bus.pc_f = pc;
        #1;
        compare("lit hit_f",     32'(bus.hit_f),   32'(e_hit));
        compare("lit taken_f",   32'(bus.taken_f), 32'(e_taken));
        compare("lit next_pc_f", bus.next_pc_f,    e_next);
    endtask

    initial begin
        nvec     = 0;
        nmis     = 0;
        check_en = 1'b0;
        bus.pc_f = 32'h100;
        idle();
        rst = 1'b1;
        model_reset();

        #2;
        lookup(32'h100, 1'b0, 1'b0, 32'h104);
        compare("lit reset target_f",  bus.target_f, 32'h0);
        compare("lit reset upd_count", 32'(bus.upd_count), 32'd0);
        compare("lit reset mis_count", 32'(bus.mispredict_count), 32'd0);
        lookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;

        applyStimulus(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b1, 32'h200);
        lookup(32'h140, 1'b0, 1'b0, 32'h144);

        bus.pc_f = 32'h100;
        applyStimulus(1'b0, 32'h100, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        compare("lit nt target kept", bus.target_f, 32'h200);
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b1, 32'h200);
        compare("lit upd_count six", 32'(bus.upd_count), 32'd6);

        // Same-cycle update and lookup: old state until after the edge.
        driveUpdate(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup(32'h100, 1'b1, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        idle();
        lookup(32'h100, 1'b1, 1'b0, 32'h104);

        applyStimulus(1'b0, 32'h300, 1'b1, 32'h80, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup(32'h300, 1'b1, 1'b1, 32'h80);
        lookup(32'h100, 1'b0, 1'b0, 32'h104);
        compare("lit upd_count wrap", 32'(bus.upd_count), 32'd1);

        applyStimulus(1'b1, 32'h300, 1'b1, 32'h999, 1'b1, 1'b1);
        lookup(32'h300, 1'b0, 1'b0, 32'h304);
        compare("lit inval upd_count", 32'(bus.upd_count), 32'd1);
        compare("lit inval mis_count", 32'(bus.mispredict_count), 32'd0);

        applyStimulus(1'b0, 32'h104,       1'b1, 32'h400, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h108,       1'b1, 32'h500, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h104,       1'b0, 32'h0,   1'b0, 1'b1);
        applyStimulus(1'b0, 32'h10C,       1'b0, 32'h0,   1'b0, 1'b1);
        applyStimulus(1'b0, 32'h1000_0104, 1'b1, 32'h600, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h108,       1'b0, 32'h0,   1'b0, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FFFC, 1'b1, 32'h10,  1'b0, 1'b0);
        applyStimulus(1'b0, 32'h104,       1'b1, 32'h700, 1'b0, 1'b1);
        compare("lit mis_count five", 32'(bus.mispredict_count), 32'd5);
        compare("lit upd_count nine", 32'(bus.upd_count), 32'd1);
        lookup(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10);
        lookup(32'h104,       1'b1, 1'b1, 32'h700);
        lookup(32'h1000_0104, 1'b0, 1'b0, 32'h1000_0108);
        lookup(32'h108,       1'b1, 1'b1, 32'h500);
        lookup(32'h10C,       1'b0, 1'b0, 32'h110);

        // Asynchronous reset while an update is pending: update must be lost.
        driveUpdate(1'b0, 32'h10C, 1'b1, 32'h900, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        lookup(32'h108, 1'b0, 1'b0, 32'h10C);
        compare("lit async upd_count", 32'(bus.upd_count), 32'd0);
        @(posedge clk);
        #1;
        idle();
        lookup(32'h10C, 1'b0, 1'b0, 32'h110);
        rst = 1'b0;

        applyStimulus(1'b0, 32'h10C, 1'b1, 32'h900, 1'b0, 1'b0);
        lookup(32'h10C, 1'b1, 1'b1, 32'h900);
        compare("lit post-reset upd_count", 32'(bus.upd_count), 32'd1);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
